mem_bus_master: RTL
===================

Name: mem_bus_master

Overview:
Bus initiator between the core's load/store stage and the byte-serial memory bus responder. It takes one RISC-V load/store request at a time, maps funct3 to the bus byte-count code (bhw), and issues a single-cycle bus request. It then waits for the responder's data-valid pulse and returns sign- or zero-extended load data, or a store completion, to the core. One transaction is outstanding at most, because the responder ignores requests while busy.

Parameters:
TIMEOUT_CYCLES, 1024, cycles spent in WAIT before aborting (used only with BUS_TIMEOUT_EN); counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
i_clk  input  1  clock; all logic on posedge
i_rst_n  input  1  synchronous active-low reset
i_req_valid  input  1  core request valid
o_req_ready  output  1  high only in IDLE; request accepted on i_req_valid & o_req_ready
i_req_write  input  1  1 = store, 0 = load
i_req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
i_req_addr  input  32  byte address; no alignment restriction
i_req_wdata  input  32  store data, LSB-aligned
o_rsp_valid  output  1  one-cycle response pulse
o_rsp_rdata  output  32  extended load data; 0 for stores and errors
o_rsp_err  output  1  illegal funct3, or timeout
o_bus_data  output  32  store data to responder
o_bus_address  output  32  address to responder
o_bus_DV  output  1  one-cycle request pulse
o_bhw  output  3  3'b001 byte, 3'b010 half, 3'b100 word
o_write_notread  output  1  1 = write
i_bus_data  input  32  read data; first byte read is in [7:0]
i_bus_DV  input  1  responder completion pulse

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - State goes to IDLE.
  - Every output is cleared to 0 except o_req_ready, which is 1.
  - The timeout counter is cleared.
- States: IDLE, ISSUE, WAIT.
  - IDLE: on handshake at cycle T, latch addr, wdata, write, funct3 and the decoded bhw.
    - Legal funct3: go to ISSUE.
    - Illegal funct3 (loads 011/110/111; stores 1xx or 011): stay IDLE. At T+1, o_rsp_valid=1, o_rsp_err=1, rdata=0. No bus activity.
  - ISSUE (cycle T+1):
    - o_bus_DV=1 for exactly this cycle.
    - o_bus_address, o_bhw, o_write_notread and o_bus_data are registered and held stable from T+1 until the response.
    - Go to WAIT.
  - WAIT: hold until i_bus_DV=1 at cycle R.
    - At R+1: state is IDLE, o_rsp_valid=1 for one cycle, o_rsp_err=0, o_req_ready=1.
    - A new request may be accepted at R+1; the responder is ready again at that point.
- Load data at R+1:
  - LB: sign-extend i_bus_data[7:0].
  - LH: sign-extend [15:0].
  - LW: [31:0].
  - LBU / LHU: zero-extend.
  - Stores return rdata=0.
- o_bus_data always carries the full i_req_wdata; the responder consumes only the low bhw bytes, little-endian.
- i_bus_DV in IDLE or ISSUE is ignored; no response is generated.
- i_req_valid outside IDLE is not accepted (o_req_ready=0).
- Reset in ISSUE or WAIT: the transaction is dropped silently with no response. The responder has no reset; after reset the core must not issue until the bus has settled (system-level rule).

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - The counter runs only in WAIT.
  - When the count reaches TIMEOUT_CYCLES without i_bus_DV, the next cycle gives o_rsp_valid=1, o_rsp_err=1, rdata=0, and state returns to IDLE.
  - A late i_bus_DV arriving in IDLE is ignored.
  - If i_bus_DV and the timeout occur in the same cycle, i_bus_DV wins and a normal response is returned.
- Undefined: no counter; WAIT lasts indefinitely.

Decomposition:
- Package mem_bus_pkg holds:
  - BHW_BYTE=3'b001, BHW_HALF=3'b010, BHW_WORD=3'b100;
  - funct3 codes F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state encoding.
- One combinational sub-module, load_extend (funct3 + raw data -> extended data), which is reusable by the core.

Test Plan:
1. LW addr 0x00001000; bus returns 0xDEADBEEF 5 cycles after DV -> o_bus_DV high exactly at T+1 with o_bhw=100 and write=0; rsp_valid at R+1 with rdata 0xDEADBEEF, err=0.
2. LB then LBU, each with i_bus_data=0x00000080 -> rdata 0xFFFFFF80, then 0x00000080. LH with 0x00008001 -> 0xFFFF8001.
3. SH addr 0x2003, wdata 0x1234ABCD -> o_bus_data 0x1234ABCD, o_bhw=010, write=1, address 0x2003; rsp rdata=0, err=0.
4. Load funct3=011 -> no o_bus_DV; at T+1 rsp_valid=1, err=1, rdata=0. Stray i_bus_DV in IDLE -> no rsp_valid.
5. Drive i_rst_n=0 while in WAIT -> next cycle all outputs 0 and ready=1. Then issue a back-to-back SW followed by LW at R+1 -> both complete in order.
6. With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no i_bus_DV -> err response 9 cycles after entering WAIT. Repeat with i_bus_DV coinciding with the 8th cycle -> normal response, err=0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the load/store bus initiator: byte-count codes,
// RISC-V load/store funct3 values, FSM states and funct3 decode helpers.
package mem_bus_pkg;

  localparam logic [2:0] BHW_BYTE = 3'b001;
  localparam logic [2:0] BHW_HALF = 3'b010;
  localparam logic [2:0] BHW_WORD = 3'b100;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [2:0] f3_to_bhw(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return BHW_BYTE;
      2'b01:   return BHW_HALF;
      2'b10:   return BHW_WORD;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Core request/response and memory-bus signals of mem_bus_master.
// master = the initiator itself, slave = the core plus the bus responder.
interface mem_bus_master_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_bus_data;
  logic [31:0] o_bus_address;
  logic        o_bus_DV;
  logic [2:0]  o_bhw;
  logic        o_write_notread;
  logic [31:0] i_bus_data;
  logic        i_bus_DV;

  modport master (
    input  i_req_valid, i_req_write, i_req_funct3, i_req_addr, i_req_wdata,
    input  i_bus_data, i_bus_DV,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_bus_data, o_bus_address, o_bus_DV, o_bhw, o_write_notread
  );

  modport slave (
    output i_req_valid, i_req_write, i_req_funct3, i_req_addr, i_req_wdata,
    output i_bus_data, i_bus_DV,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_bus_data, o_bus_address, o_bus_DV, o_bhw, o_write_notread
  );
endinterface

// File: rtl/mem_bus_master_load_extend.sv
// Combinational load-data extension (LB/LH/LW/LBU/LHU); reusable by the core.
module load_extend
  import mem_bus_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  // NOTE: always_comb assigns every output first so no path can infer a latch.
  always_comb begin
    data = raw;
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   data = {24'h0, raw[7:0]};
      F3_HU:   data = {16'h0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// Single-outstanding load/store initiator onto the byte-serial memory bus.
// Optional response timeout in WAIT is enabled by defining BUS_TIMEOUT_EN.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic              i_clk,
  input logic              i_rst_n,
  mem_bus_master_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [2:0]  f3_q, bhw_q;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] ext_data;
  logic        handshake, req_legal, timeout_hit;

  assign handshake = bus.i_req_valid && (state_q == ST_IDLE);
  assign req_legal = f3_legal(bus.i_req_write, bus.i_req_funct3);

  load_extend u_load_extend (
    .funct3 (f3_q),
    .raw    (bus.i_bus_data),
    .data   (ext_data)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Counter only advances in WAIT, so it is already zero on entry from ISSUE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                                cnt_q <= '0;
    else if (state_q == ST_WAIT && !timeout_hit) cnt_q <= cnt_q + 1'b1;
    else                                         cnt_q <= '0;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          if (req_legal) begin
            state_d = ST_ISSUE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // A completion in the timeout cycle still wins over the timeout.
        if (bus.i_bus_DV) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? 32'h0 : ext_data;
        end else if (timeout_hit) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      f3_q        <= '0;
      bhw_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (handshake) begin
        addr_q  <= bus.i_req_addr;
        wdata_q <= bus.i_req_wdata;
        write_q <= bus.i_req_write;
        f3_q    <= bus.i_req_funct3;
        bhw_q   <= req_legal ? f3_to_bhw(bus.i_req_funct3) : 3'b000;
      end
    end
  end

  assign bus.o_req_ready     = (state_q == ST_IDLE);
  assign bus.o_bus_DV        = (state_q == ST_ISSUE);
  assign bus.o_bus_address   = addr_q;
  assign bus.o_bus_data      = wdata_q;
  assign bus.o_bhw           = bhw_q;
  assign bus.o_write_notread = write_q;
  assign bus.o_rsp_valid     = rsp_valid_q;
  assign bus.o_rsp_err       = rsp_err_q;
  assign bus.o_rsp_rdata     = rsp_rdata_q;

endmodule
